// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification and ordered reset-domain release.
// Optional lock watchdog (timeout, retries, FAULT) enabled by defining PLL_SEQ_WATCHDOG_EN.
module pll_reset_seq #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int STAGES              = 3,
  parameter int STAGE_GAP           = 64,
  parameter int MAX_RETRIES         = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [STAGES-1:0] stage_rst_n,
  output logic              ready,
  output logic [2:0]        retry_count,
  output logic              fault
);

  localparam int RstW = (PLL_RESET_CYCLES > 1) ? $clog2(PLL_RESET_CYCLES) : 1;
  localparam int StbW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GapW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  if (LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || PLL_RESET_CYCLES < 1 ||
      STAGES < 1 || STAGE_GAP < 1 || MAX_RETRIES < 1) begin : g_bad_params
    $error("pll_reset_seq: all cycle/count parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [StbW-1:0]   stb_cnt_q, stb_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [STAGES-1:0] stage_q, stage_d;

`ifdef PLL_SEQ_WATCHDOG_EN
  localparam int ToW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              to_max;
  logic [2:0]        retry_q, retry_d;
`endif

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      state_q   <= S_PLL_RST;
      rst_cnt_q <= '0;
      stb_cnt_q <= '0;
      gap_cnt_q <= '0;
      stage_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], pll_lock};
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      stage_q   <= stage_d;
    end
  end

`ifdef PLL_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      retry_q  <= 3'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
      retry_q  <= retry_d;
    end
  end

  // Timeout counter saturates so a lock that wins on the last cycle cannot wrap it.
  assign to_max = (to_cnt_q == ToW'(LOCK_TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stb_cnt_d = stb_cnt_q;
    gap_cnt_d = gap_cnt_q;
    stage_d   = stage_q;
`ifdef PLL_SEQ_WATCHDOG_EN
    to_cnt_d  = to_cnt_q;
    retry_d   = retry_q;
`endif

    unique case (state_q)
      S_PLL_RST: begin
        stage_d   = '0;
        stb_cnt_d = '0;
        gap_cnt_d = '0;
`ifdef PLL_SEQ_WATCHDOG_EN
        to_cnt_d  = '0;
`endif
        if (rst_cnt_q == RstW'(PLL_RESET_CYCLES - 1)) begin
          rst_cnt_d = '0;
          state_d   = S_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end

      S_WAIT_LOCK: begin
`ifdef PLL_SEQ_WATCHDOG_EN
        if (!to_max) to_cnt_d = to_cnt_q + ToW'(1);
`endif
        if (lock_s) begin
          state_d = S_STABLE;
`ifdef PLL_SEQ_WATCHDOG_EN
        end else if (to_max) begin
          retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
          state_d = (int'(retry_d) == MAX_RETRIES) ? S_FAULT : S_PLL_RST;
`endif
        end
      end

      S_STABLE: begin
        if (!lock_s) begin
          stb_cnt_d = '0;
          state_d   = S_WAIT_LOCK;
        end else if (stb_cnt_q == StbW'(LOCK_STABLE_CYCLES - 1)) begin
          stb_cnt_d = '0;
          gap_cnt_d = '0;
          stage_d   = STAGES'(1);
          state_d   = (STAGES == 1) ? S_RUN : S_RELEASE;
        end else begin
          stb_cnt_d = stb_cnt_q + StbW'(1);
        end
      end

      S_RELEASE: begin
        if (!lock_s) begin
          stage_d   = '0;
          gap_cnt_d = '0;
          state_d   = S_PLL_RST;
        end else if (gap_cnt_q == GapW'(STAGE_GAP - 1)) begin
          gap_cnt_d = '0;
          stage_d   = (stage_q << 1) | STAGES'(1);
          if (stage_d[STAGES-1]) state_d = S_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      S_RUN: begin
        if (!lock_s) begin
          stage_d = '0;
          state_d = S_PLL_RST;
        end
      end

      S_FAULT: begin
        stage_d = '0;
      end

      default: begin
        stage_d = '0;
        state_d = S_PLL_RST;
      end
    endcase

`ifdef PLL_SEQ_WATCHDOG_EN
    if (state_d == S_RUN) retry_d = 3'd0;
`endif
  end

  assign pll_reset   = (state_q == S_PLL_RST) || (state_q == S_FAULT);
  assign ready       = (state_q == S_RUN);
  assign stage_rst_n = stage_q;

`ifdef PLL_SEQ_WATCHDOG_EN
  assign retry_count = retry_q;
  assign fault       = (state_q == S_FAULT);
`else
  assign retry_count = 3'd0;
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - randomized scoreboard bench for pll_reset_seq against a behavioural model.
// Honours PLL_SEQ_WATCHDOG_EN the same way as the design.
module tb_pll_reset_seq;

  localparam int LSC  = 8;
  localparam int TO   = 100;
  localparam int PRC  = 4;
  localparam int NST  = 3;
  localparam int GAP  = 5;
  localparam int MAXR = 2;
`ifdef PLL_SEQ_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pll_lock = 1'b0;
  logic           pll_reset;
  logic [NST-1:0] stage_rst_n;
  logic           ready;
  logic [2:0]     retry_count;
  logic           fault;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(TO),
    .PLL_RESET_CYCLES   (PRC),
    .STAGES             (NST),
    .STAGE_GAP          (GAP),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .stage_rst_n(stage_rst_n),
    .ready      (ready),
    .retry_count(retry_count),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           pll_reset;
    logic [NST-1:0] stage;
    logic           ready;
    logic [2:0]     retry;
    logic           fault;
    string          tag;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Behavioural model: pulse time left, wait/stability progress, number of released domains.
  bit m_s1, m_ls;
  int m_rst_left, m_waited, m_run, m_released, m_since, m_retry;
  bit m_checking, m_fault;

  function void model_reset();
    m_s1 = 0; m_ls = 0;
    m_rst_left = PRC; m_waited = 0; m_run = 0;
    m_released = 0; m_since = 0; m_retry = 0;
    m_checking = 0; m_fault = 0;
  endfunction

  function void model_edge(bit lock_in);
    bit ls;
    ls   = m_ls;
    m_ls = m_s1;
    m_s1 = lock_in;
    if (m_fault) return;
    if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) begin
        m_waited = 0; m_checking = 0; m_run = 0;
      end
    end else if (m_released > 0) begin
      if (!ls) begin
        m_released = 0;
        m_rst_left = PRC;
      end else if (m_released < NST) begin
        m_since++;
        if (m_since == m_released * GAP) m_released++;
        if (m_released == NST) m_retry = 0;
      end
    end else if (m_checking) begin
      if (!ls) begin
        m_checking = 0; m_run = 0;
      end else begin
        m_run++;
        if (m_run == LSC) begin
          m_checking = 0; m_released = 1; m_since = 0;
          if (NST == 1) m_retry = 0;
        end
      end
    end else begin
      m_waited++;
      if (ls) begin
        m_checking = 1; m_run = 0;
      end else if (WDOG && m_waited >= TO) begin
        m_retry = (m_retry < 7) ? m_retry + 1 : 7;
        if (m_retry == MAXR) m_fault = 1;
        else m_rst_left = PRC;
      end
    end
  endfunction

  function void push_exp(string tag);
    exp_t e;
    e.pll_reset = (m_rst_left > 0) || m_fault;
    e.stage     = NST'((1 << m_released) - 1);
    e.ready     = (m_released == NST);
    e.retry     = 3'(m_retry);
    e.fault     = m_fault;
    e.tag       = tag;
    e.cyc       = cyc;
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit nrst, input bit lock, input string tag);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) model_edge(pll_lock);
    else model_reset();
    rst_n    = nrst;
    pll_lock = lock;
    if (!rst_n) model_reset();
    push_exp(tag);
  endtask

  task automatic hold(input int n, input bit nrst, input bit lock, input string tag);
    for (int i = 0; i < n; i++) step(nrst, lock, tag);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({pll_reset, stage_rst_n, ready, retry_count, fault} !==
          {e.pll_reset, e.stage, e.ready, e.retry, e.fault}) begin
        n_err++;
        $display("FAIL %s cyc=%0d got pll_reset=%b stage=%b ready=%b retry=%0d fault=%b, want pll_reset=%b stage=%b ready=%b retry=%0d fault=%b",
                 e.tag, e.cyc, pll_reset, stage_rst_n, ready, retry_count, fault,
                 e.pll_reset, e.stage, e.ready, e.retry, e.fault);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int len;
    bit lk;
    model_reset();
    hold(3, 0, 0, "reset_state");

    hold($urandom_range(6, 14), 1, 0, "nominal_prelock");
    hold(40, 1, 1, "nominal");

    hold($urandom_range(1, 4), 1, 0, "run_lock_loss");
    hold(12, 1, 0, "run_lock_loss_rst");

    hold(5, 1, 1, "glitch_high");
    hold(1, 1, 0, "glitch_low");
    hold(30, 1, 1, "glitch_relock");

    hold(3, 1, 0, "pre_midrel_drop");
    for (int i = 0; i < 80 && m_released != 2; i++) step(1, 1, "to_stage1");
    step(0, 1, "midrel_reset");
    hold(35, 1, 1, "midrel_restart");

    hold(2, 0, 0, "never_lock_reset");
    hold(WDOG ? 260 : 1000, 1, 0, "never_lock");
    hold(10, 1, 1, "fault_hold");
    hold(2, 0, 1, "fault_clear");

    for (int k = 0; k < 40; k++) begin
      lk  = 1'($urandom_range(0, 1));
      len = lk ? $urandom_range(1, 40) : $urandom_range(1, 120);
      if ($urandom_range(0, 14) == 0) step(0, lk, "rand_rst");
      hold(len, 1, lk, "random");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
